// File: rtl/bdc_sync_measure_pkg.sv
// BDC SYNC measurement shared definitions.
// Width constant is shared with bdc_clk_pulse_generator.
package bdc_sync_measure_pkg;

    localparam int LEN_W = 32;

    localparam int DEF_HOST_LOW_CYCLES = 20000;
    localparam int DEF_SETTLE_CYCLES   = 8;
    localparam int DEF_TIMEOUT_CYCLES  = 1000000;
    localparam int DEF_MIN_LENGTH      = 128;

    typedef logic [LEN_W-1:0] len_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE_LOW,
        ST_SETTLE,
        ST_WAIT_HIGH,
        ST_WAIT_FALL,
        ST_MEASURE
    } sync_state_t;

    function automatic len_t sat_inc(input len_t v);
        return (v == '1) ? v : v + len_t'(1);
    endfunction

endpackage

// File: rtl/bdc_sync_ff.sv
// Two-flop synchronizer for the BKGD pin.
// Resets to the idle (released, pulled-up) level.
module bdc_sync_ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bdc_sync_measure.sv
// BDC SYNC request generator and target low-pulse measurement.
// Result feeds the BDC bit-clock pulse generator.
module bdc_sync_measure
    import bdc_sync_measure_pkg::*;
#(
    parameter int HOST_LOW_CYCLES = DEF_HOST_LOW_CYCLES,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int MIN_LENGTH      = DEF_MIN_LENGTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bkgd_in,
    output logic             bkgd_drive_low,
    output logic             busy,
    output logic [LEN_W-1:0] sync_length,
    output logic             set_sync_length,
    output logic             sync_error
);

    localparam len_t HOST_LAST   = len_t'(HOST_LOW_CYCLES - 1);
    localparam len_t SETTLE_LAST = len_t'(SETTLE_CYCLES - 1);
    localparam len_t TO_LAST     = len_t'(TIMEOUT_CYCLES - 1);
    localparam len_t MIN_LEN     = len_t'(MIN_LENGTH);

    sync_state_t state, state_nxt;
    len_t        cyc_cnt, cyc_nxt;
    len_t        len_cnt, len_nxt;
    len_t        length_nxt;
    logic        set_nxt;
    logic        err_nxt;
    logic        bkgd_s;
    logic        timeout;
    len_t        cyc_inc;

    bdc_sync_ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bkgd_in),
        .q   (bkgd_s)
    );

    assign busy           = (state != ST_IDLE);
    assign bkgd_drive_low = (state == ST_DRIVE_LOW);
    assign timeout        = (cyc_cnt == TO_LAST);
    assign cyc_inc        = cyc_cnt + len_t'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            cyc_cnt         <= '0;
            len_cnt         <= '0;
            sync_length     <= '0;
            set_sync_length <= 1'b0;
            sync_error      <= 1'b0;
        end else begin
            state           <= state_nxt;
            cyc_cnt         <= cyc_nxt;
            len_cnt         <= len_nxt;
            sync_length     <= length_nxt;
            set_sync_length <= set_nxt;
            sync_error      <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cyc_nxt    = cyc_cnt;
        len_nxt    = len_cnt;
        length_nxt = sync_length;
        set_nxt    = 1'b0;
        err_nxt    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_DRIVE_LOW;
                    cyc_nxt   = '0;
                end
            end
            ST_DRIVE_LOW: begin
                cyc_nxt = cyc_inc;
                if (cyc_cnt == HOST_LAST) begin
                    state_nxt = ST_SETTLE;
                    cyc_nxt   = '0;
                end
            end
            ST_SETTLE: begin
                cyc_nxt = cyc_inc;
                if (cyc_cnt == SETTLE_LAST) begin
                    state_nxt = ST_WAIT_HIGH;
                    cyc_nxt   = '0;
                end
            end
            // Timeout budget spans all three target-wait states.
            ST_WAIT_HIGH: begin
                cyc_nxt = cyc_inc;
                if (timeout) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                end else if (bkgd_s) begin
                    state_nxt = ST_WAIT_FALL;
                end
            end
            ST_WAIT_FALL: begin
                cyc_nxt = cyc_inc;
                if (timeout) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                end else if (!bkgd_s) begin
                    state_nxt = ST_MEASURE;
                    len_nxt   = len_t'(1);
                end
            end
            ST_MEASURE: begin
                cyc_nxt = cyc_inc;
                if (timeout) begin
                    state_nxt = ST_IDLE;
                    err_nxt   = 1'b1;
                end else if (!bkgd_s) begin
                    len_nxt = sat_inc(len_cnt);
                end else begin
                    state_nxt = ST_IDLE;
                    if (len_cnt < MIN_LEN) begin
                        err_nxt = 1'b1;
                    end else begin
                        set_nxt    = 1'b1;
                        length_nxt = len_cnt;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (state_nxt == ST_IDLE && state != ST_IDLE) begin
            cyc_nxt = '0;
        end
    end

endmodule

// File: tb/tb_bdc_sync_measure.sv
// Directed bench for bdc_sync_measure with a simple open-drain target.
module tb_bdc_sync_measure;

    localparam int HOST = 2000;
    localparam int SETL = 8;
    localparam int TOUT = 3000;
    localparam int MINL = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        bkgd_in;
    logic        bkgd_drive_low;
    logic        busy;
    logic [31:0] sync_length;
    logic        set_sync_length;
    logic        sync_error;

    logic tgt_low = 1'b0;
    int   tgt_dly = 20;
    int   tgt_len = 0;

    int checks = 0;
    int errors = 0;
    int both_cnt = 0;

    int n_busy, n_drv, n_mid, n_after, busy_after;
    logic busy_first, end_set, end_err, hung;

    typedef struct {
        string name;
        int    len;
        logic  exp_set;
        logic  exp_err;
        int    exp_length;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    assign bkgd_in = !(bkgd_drive_low || tgt_low);

    bdc_sync_measure #(
        .HOST_LOW_CYCLES (HOST),
        .SETTLE_CYCLES   (SETL),
        .TIMEOUT_CYCLES  (TOUT),
        .MIN_LENGTH      (MINL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .bkgd_in         (bkgd_in),
        .bkgd_drive_low  (bkgd_drive_low),
        .busy            (busy),
        .sync_length     (sync_length),
        .set_sync_length (set_sync_length),
        .sync_error      (sync_error)
    );

    always @(negedge clk) begin
        if (set_sync_length && sync_error) both_cnt++;
    end

    // Target answers each host release with one low pulse.
    initial begin
        forever begin
            @(negedge bkgd_drive_low);
            if (tgt_len > 0) begin
                repeat (tgt_dly) @(negedge clk);
                tgt_low = 1'b1;
                repeat (tgt_len) @(negedge clk);
                tgt_low = 1'b0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    // Called just after a negedge; runs one request until busy drops.
    task automatic run_sync(input int mid_start, input int limit);
        n_busy = 0;
        n_drv = 0;
        n_mid = 0;
        n_after = 0;
        busy_after = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_first = busy;
        while (busy && n_busy < limit) begin
            n_busy++;
            if (bkgd_drive_low) n_drv++;
            if (set_sync_length || sync_error) n_mid++;
            start = (n_busy == mid_start);
            @(negedge clk);
        end
        start = 1'b0;
        hung = busy;
        end_set = set_sync_length;
        end_err = sync_error;
        repeat (6) begin
            @(negedge clk);
            if (set_sync_length || sync_error) n_after++;
            if (busy) busy_after++;
        end
    endtask

    initial begin
        vecs[0] = '{"len1475", 1475, 1'b1, 1'b0, 1475};
        vecs[1] = '{"short100", 100, 1'b0, 1'b1, 1475};
        vecs[2] = '{"min128", 128, 1'b1, 1'b0, 128};
        vecs[3] = '{"below127", 127, 1'b0, 1'b1, 128};
        vecs[4] = '{"len300", 300, 1'b1, 1'b0, 300};

        rst = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_drive", bkgd_drive_low, 0);
        chk("rst_busy", busy, 0);
        chk("rst_len", sync_length, 0);
        chk("rst_set", set_sync_length, 0);
        chk("rst_err", sync_error, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            tgt_dly = 20;
            tgt_len = vecs[i].len;
            run_sync(0, 20000);
            chk({vecs[i].name, "_busy1"}, busy_first, 1);
            chk({vecs[i].name, "_drv"}, n_drv, HOST);
            chk({vecs[i].name, "_hung"}, hung, 0);
            chk({vecs[i].name, "_mid"}, n_mid, 0);
            chk({vecs[i].name, "_set"}, end_set, vecs[i].exp_set);
            chk({vecs[i].name, "_err"}, end_err, vecs[i].exp_err);
            chk({vecs[i].name, "_len"}, sync_length, vecs[i].exp_length);
            chk({vecs[i].name, "_after"}, n_after, 0);
        end

        // Silent target; extra start lands on the timeout return edge.
        tgt_len = 0;
        run_sync(HOST + SETL + TOUT, 20000);
        chk("to_busy", n_busy, HOST + SETL + TOUT);
        chk("to_err", end_err, 1);
        chk("to_set", end_set, 0);
        chk("to_len", sync_length, 300);
        chk("to_start_ign", busy_after, 0);
        chk("to_after", n_after, 0);

        // Reset 500 cycles into the host drive.
        tgt_len = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (499) @(negedge clk);
        chk("rd_drive_pre", bkgd_drive_low, 1);
        #2 rst = 1'b0;
        #1;
        chk("rd_drive", bkgd_drive_low, 0);
        chk("rd_busy", busy, 0);
        chk("rd_len", sync_length, 0);
        chk("rd_set", set_sync_length, 0);
        chk("rd_err", sync_error, 0);
        @(negedge clk);
        rst = 1'b1;
        n_after = 0;
        busy_after = 0;
        repeat (40) begin
            @(negedge clk);
            if (set_sync_length || sync_error) n_after++;
            if (busy || bkgd_drive_low) busy_after++;
        end
        chk("rd_strobe", n_after, 0);
        chk("rd_idle", busy_after, 0);

        // Second start during MEASURE.
        tgt_dly = 20;
        tgt_len = 1475;
        run_sync(HOST + SETL + 500, 20000);
        chk("ms_set", end_set, 1);
        chk("ms_err", end_err, 0);
        chk("ms_len", sync_length, 1475);
        chk("ms_mid", n_mid, 0);
        chk("ms_after", n_after, 0);
        chk("ms_busy", busy_after, 0);

        chk("set_err_both", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
